// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Autonomous stage/butterfly sequencer for an in-place radix-2 DIF FFT.
// One start pulse runs all NUMSTAGES stages. Each enabled RUN cycle issues
// one butterfly read. The matching write follows BF_LATENCY enabled cycles
// later on the opposite bank pair.
//
// Bank mapping: sample n sits in bank pairbase + (XOR of all bits of n), at
// address n>>1. top and bot differ in exactly one bit, so their bit-parities
// differ and the two reads of a butterfly never hit the same bank.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, ld_data_r   begin a transform (only when input data is loaded)
//   en_r               advance enable; low freezes RUN/DRAIN
//   busy, stage_num    transform in progress, current stage
//   rd_en, rd_addr0..3 read strobe and per-bank read addresses
//   wr_en, wr_addr0..3 write strobe and per-bank write addresses
//   m0_s / m1_s        read / write swap (top sample on odd-parity bank)
//   m2_s / m3_s        read / write bank pair select
//   tw_addr            twiddle ROM address
//   stage_done         one-cycle pulse at the end of each stage
//   fft_done           one-cycle pulse at the end of the last stage
//   res_pair           pair holding the result
// Optional build macro FFT_INVERSE_EN adds input inverse and output tw_conj.
module fft_stage_sequencer #(
    parameter int NUMSTAGES  = 5,
    parameter int BF_LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef FFT_INVERSE_EN
    input  logic                         inverse,
    output logic                         tw_conj,
`endif
    input  logic                         start,
    input  logic                         ld_data_r,
    input  logic                         en_r,
    output logic                         busy,
    output logic [$clog2(NUMSTAGES)-1:0] stage_num,
    output logic                         rd_en,
    output logic                         wr_en,
    output logic [NUMSTAGES-2:0]         rd_addr0,
    output logic [NUMSTAGES-2:0]         rd_addr1,
    output logic [NUMSTAGES-2:0]         rd_addr2,
    output logic [NUMSTAGES-2:0]         rd_addr3,
    output logic [NUMSTAGES-2:0]         wr_addr0,
    output logic [NUMSTAGES-2:0]         wr_addr1,
    output logic [NUMSTAGES-2:0]         wr_addr2,
    output logic [NUMSTAGES-2:0]         wr_addr3,
    output logic                         m0_s,
    output logic                         m1_s,
    output logic                         m2_s,
    output logic                         m3_s,
    output logic [NUMSTAGES-2:0]         tw_addr,
    output logic                         stage_done,
    output logic                         fft_done,
    output logic                         res_pair
);

    localparam int AW = NUMSTAGES - 1;
    localparam int SW = $clog2(NUMSTAGES);
    localparam int L  = BF_LATENCY;
    localparam logic [AW-1:0]        J_LAST   = '1;
    localparam logic [SW-1:0]        S_LAST   = SW'(NUMSTAGES - 1);
    localparam logic [AW-1:0]        AONE     = AW'(1);
    localparam logic [NUMSTAGES-1:0] NONE     = NUMSTAGES'(1);
    // All delay-line slots except the one being written this cycle.
    localparam logic [L-1:0]         HEAD_MASK = {L{1'b1}} >> 1;
    localparam logic                 RES_PAIR  = (NUMSTAGES % 2) == 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_t;

    state_t         state;
    logic [AW-1:0]  j;
    logic [SW-1:0]  s;
`ifdef FFT_INVERSE_EN
    logic           inv_lat;
`endif

    // Write delay line: valid, top/bot bank addresses, top parity.
    logic [L-1:0]   vld_pipe;
    logic [L-1:0]   par_pipe;
    logic [AW-1:0]  ta_pipe [L];
    logic [AW-1:0]  ba_pipe [L];

    logic           adv, issue;
    int             p;
    logic [NUMSTAGES-1:0] jx, top, bot;
    logic [AW-1:0]  mask, jm, tw;
    logic           top_par;
    logic [AW-1:0]  rd_nxt [4];
    logic [AW-1:0]  wr_nxt [4];

    assign stage_num = s;
    assign adv   = en_r && (state == RUN || state == DRAIN);
    assign issue = en_r && (state == RUN);

    always_comb begin
        p       = NUMSTAGES - 1 - int'(s);
        jx      = {1'b0, j};
        // For s=0, p=AW and the shift wraps to 0, giving an all-ones mask.
        mask    = (AONE << p) - AONE;
        jm      = j & mask;
        top     = ((jx >> p) << (p + 1)) | {1'b0, jm};
        bot     = top | (NONE << p);
        top_par = ^top;
        tw      = jm << s;
        for (int b = 0; b < 4; b++) begin
            rd_nxt[b] = '0;
            wr_nxt[b] = '0;
        end
        // Bank index = {pair, parity}; the partner sample takes the other bank.
        rd_nxt[{s[0],  top_par}]       = top[NUMSTAGES-1:1];
        rd_nxt[{s[0], ~top_par}]       = bot[NUMSTAGES-1:1];
        wr_nxt[{~s[0],  par_pipe[L-1]}] = ta_pipe[L-1];
        wr_nxt[{~s[0], ~par_pipe[L-1]}] = ba_pipe[L-1];
    end

    // Control FSM and read-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            j          <= '0;
            s          <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr0   <= '0;
            rd_addr1   <= '0;
            rd_addr2   <= '0;
            rd_addr3   <= '0;
            m0_s       <= 1'b0;
            m2_s       <= 1'b0;
            m3_s       <= 1'b0;
            tw_addr    <= '0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
            res_pair   <= 1'b0;
`ifdef FFT_INVERSE_EN
            inv_lat    <= 1'b0;
            tw_conj    <= 1'b0;
`endif
        end else begin
            rd_en      <= 1'b0;
            rd_addr0   <= '0;
            rd_addr1   <= '0;
            rd_addr2   <= '0;
            rd_addr3   <= '0;
            m0_s       <= 1'b0;
            m2_s       <= 1'b0;
            m3_s       <= 1'b0;
            tw_addr    <= '0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
`ifdef FFT_INVERSE_EN
            tw_conj    <= 1'b0;
`endif
            // m2/m3/tw_conj are set from the state being entered so they are
            // valid for the whole time the FSM sits in RUN/DRAIN.
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && ld_data_r) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        s        <= '0;
                        j        <= '0;
                        res_pair <= 1'b0;
                        m2_s     <= 1'b0;
                        m3_s     <= 1'b1;
`ifdef FFT_INVERSE_EN
                        inv_lat  <= inverse;
                        tw_conj  <= inverse;
`endif
                    end
                end
                RUN: begin
                    m2_s <= s[0];
                    m3_s <= ~s[0];
`ifdef FFT_INVERSE_EN
                    tw_conj <= inv_lat;
`endif
                    if (en_r) begin
                        rd_en    <= 1'b1;
                        m0_s     <= top_par;
                        tw_addr  <= tw;
                        rd_addr0 <= rd_nxt[0];
                        rd_addr1 <= rd_nxt[1];
                        rd_addr2 <= rd_nxt[2];
                        rd_addr3 <= rd_nxt[3];
                        if (j == J_LAST) begin
                            state <= DRAIN;
`ifdef FFT_INVERSE_EN
                            tw_conj <= 1'b0;
`endif
                        end else begin
                            j <= j + AONE;
                        end
                    end
                end
                DRAIN: begin
                    m2_s <= s[0];
                    m3_s <= ~s[0];
                    // Leave once the write going out this cycle is the last one.
                    if (en_r && (vld_pipe & HEAD_MASK) == '0) begin
                        state <= STEP;
                        m2_s  <= 1'b0;
                        m3_s  <= 1'b0;
                    end
                end
                STEP: begin
                    stage_done <= 1'b1;
                    if (s == S_LAST) begin
                        fft_done <= 1'b1;
                        res_pair <= RES_PAIR;
                        s        <= '0;
                        state    <= IDLE;
                    end else begin
                        s     <= s + SW'(1);
                        j     <= '0;
                        state <= RUN;
                        m2_s  <= ~s[0];
                        m3_s  <= s[0];
`ifdef FFT_INVERSE_EN
                        tw_conj <= inv_lat;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write delay line and write-side outputs; moves only on enabled
    // RUN/DRAIN cycles so a stall freezes reads and writes together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            par_pipe <= '0;
            for (int i = 0; i < L; i++) begin
                ta_pipe[i] <= '0;
                ba_pipe[i] <= '0;
            end
            wr_en    <= 1'b0;
            m1_s     <= 1'b0;
            wr_addr0 <= '0;
            wr_addr1 <= '0;
            wr_addr2 <= '0;
            wr_addr3 <= '0;
        end else begin
            wr_en    <= 1'b0;
            m1_s     <= 1'b0;
            wr_addr0 <= '0;
            wr_addr1 <= '0;
            wr_addr2 <= '0;
            wr_addr3 <= '0;
            if (adv) begin
                vld_pipe[0] <= issue;
                par_pipe[0] <= top_par;
                ta_pipe[0]  <= top[NUMSTAGES-1:1];
                ba_pipe[0]  <= bot[NUMSTAGES-1:1];
                for (int i = 1; i < L; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    par_pipe[i] <= par_pipe[i-1];
                    ta_pipe[i]  <= ta_pipe[i-1];
                    ba_pipe[i]  <= ba_pipe[i-1];
                end
                if (vld_pipe[L-1]) begin
                    wr_en    <= 1'b1;
                    m1_s     <= par_pipe[L-1];
                    wr_addr0 <= wr_nxt[0];
                    wr_addr1 <= wr_nxt[1];
                    wr_addr2 <= wr_nxt[2];
                    wr_addr3 <= wr_nxt[3];
                end
            end
        end
    end

endmodule
